// File: rtl/vpi_stream_pkg.sv
// vpi_stream_pkg: byte-stream constants and keep helpers shared by the VPI packer and unpacker.
package vpi_stream_pkg;
    localparam int BYTE_WIDTH = 8;

    function automatic logic [4:0] keep_popcount(input logic [15:0] keep);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) n = n + 5'(keep[i]);
        return n;
    endfunction
endpackage

// File: rtl/vpi_byte_packer_if.sv
// vpi_byte_packer_if: byte-in / word-out stream bus; slave is the packer's view, master the environment's.
interface vpi_byte_packer_if #(parameter int BUS_WIDTH = 4);
    import vpi_stream_pkg::*;
    logic [BYTE_WIDTH-1:0]           s_axis_tdata;
    logic                            s_axis_tvalid;
    logic                            s_axis_tready;
    logic                            s_axis_tlast;
    logic [BUS_WIDTH*BYTE_WIDTH-1:0] m_axis_tdata;
    logic [BUS_WIDTH-1:0]            m_axis_tkeep;
    logic                            m_axis_tvalid;
    logic                            m_axis_tready;
    logic                            m_axis_tlast;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
    );
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/vpi_axis_reg.sv
// vpi_axis_reg: output register stage; holds a word stable until the sink accepts it.
module vpi_axis_reg
    import vpi_stream_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_load,
    input  logic [WIDTH*BYTE_WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0]            i_keep,
    input  logic                        i_last,
    input  logic                        i_ready,
    output logic                        o_valid,
    output logic [WIDTH*BYTE_WIDTH-1:0] o_data,
    output logic [WIDTH-1:0]            o_keep,
    output logic                        o_last,
    output logic                        o_can_load
);
    logic                        r_valid;
    logic                        r_last;
    logic [WIDTH*BYTE_WIDTH-1:0] r_data;
    logic [WIDTH-1:0]            r_keep;

    // Loading is only legal when empty or draining, so a stalled word never changes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_keep  <= i_keep;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_keep     = r_keep;
    assign o_last     = r_last;
    assign o_can_load = !r_valid | i_ready;
endmodule

// File: rtl/vpi_byte_packer.sv
// vpi_byte_packer: packs a byte stream into little-endian BUS_WIDTH-byte words with tkeep/tlast.
module vpi_byte_packer
    import vpi_stream_pkg::*;
#(
    parameter int BUS_WIDTH = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 aclk,
    input  logic                 arstn,
    vpi_byte_packer_if.slave     bus,
    output logic [CNT_WIDTH-1:0] byte_count
);
    localparam int IDX_W = BUS_WIDTH > 1 ? $clog2(BUS_WIDTH) : 1;
    localparam int DW    = BUS_WIDTH * BYTE_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUS_WIDTH - 1);

    logic                 r_rdy;
    logic                 r_acc_full;
    logic                 r_acc_last;
    logic [IDX_W-1:0]     r_idx;
    logic [DW-1:0]        r_acc_data;
    logic [BUS_WIDTH-1:0] r_acc_keep;
    logic [CNT_WIDTH-1:0] r_byte_count;

    logic [DW-1:0]        w_base_data, w_asm_data, w_load_data;
    logic [BUS_WIDTH-1:0] w_base_keep, w_asm_keep, w_load_keep;
    logic [IDX_W-1:0]     w_base_idx;
    logic                 w_can_load, w_out_fire, w_in_fire, w_complete;
    logic                 w_load, w_asm_to_out, w_load_last;

    // A held full word is leaving whenever a byte is accepted, so new bytes start from an empty word.
    assign w_base_data = r_acc_full ? '0 : r_acc_data;
    assign w_base_keep = r_acc_full ? '0 : r_acc_keep;
    assign w_base_idx  = r_acc_full ? '0 : r_idx;

    always_comb begin
        w_asm_data = w_base_data;
        w_asm_keep = w_base_keep;
        for (int b = 0; b < BUS_WIDTH; b++) begin
            if (IDX_W'(b) == w_base_idx) begin
                w_asm_data[b*BYTE_WIDTH +: BYTE_WIDTH] = bus.s_axis_tdata;
                w_asm_keep[b] = 1'b1;
            end
        end
    end

    assign bus.s_axis_tready = r_rdy & (!r_acc_full | w_out_fire);
    assign w_out_fire   = bus.m_axis_tvalid & bus.m_axis_tready;
    assign w_in_fire    = bus.s_axis_tvalid & bus.s_axis_tready;
    assign w_complete   = w_in_fire & ((w_base_idx == LAST_IDX) | bus.s_axis_tlast);
    assign w_load       = w_can_load & (r_acc_full | w_complete);
    assign w_asm_to_out = w_load & !r_acc_full;
    assign w_load_data  = r_acc_full ? r_acc_data : w_asm_data;
    assign w_load_keep  = r_acc_full ? r_acc_keep : w_asm_keep;
    assign w_load_last  = r_acc_full ? r_acc_last : bus.s_axis_tlast;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_rdy        <= 1'b0;
            r_acc_full   <= 1'b0;
            r_acc_last   <= 1'b0;
            r_idx        <= '0;
            r_acc_data   <= '0;
            r_acc_keep   <= '0;
            r_byte_count <= '0;
        end else begin
            r_rdy <= 1'b1;
            if (w_complete && !w_asm_to_out) begin
                r_acc_data <= w_asm_data;
                r_acc_keep <= w_asm_keep;
                r_acc_last <= bus.s_axis_tlast;
                r_acc_full <= 1'b1;
                r_idx      <= '0;
            end else if (w_in_fire && !w_complete) begin
                r_acc_data <= w_asm_data;
                r_acc_keep <= w_asm_keep;
                r_acc_full <= 1'b0;
                r_idx      <= w_base_idx + IDX_W'(1);
            end else if (w_load) begin
                r_acc_data <= '0;
                r_acc_keep <= '0;
                r_acc_last <= 1'b0;
                r_acc_full <= 1'b0;
                r_idx      <= '0;
            end
            if (w_out_fire)
                r_byte_count <= r_byte_count + CNT_WIDTH'(keep_popcount(16'(bus.m_axis_tkeep)));
        end
    end

    assign byte_count = r_byte_count;

    vpi_axis_reg #(.WIDTH(BUS_WIDTH)) u_out (
        .i_clk      (aclk),
        .i_rst_n    (arstn),
        .i_load     (w_load),
        .i_data     (w_load_data),
        .i_keep     (w_load_keep),
        .i_last     (w_load_last),
        .i_ready    (bus.m_axis_tready),
        .o_valid    (bus.m_axis_tvalid),
        .o_data     (bus.m_axis_tdata),
        .o_keep     (bus.m_axis_tkeep),
        .o_last     (bus.m_axis_tlast),
        .o_can_load (w_can_load)
    );
endmodule
